skew_mask_select: RTL
=====================

Name: skew_mask_select

Overview:
- Pipelined N-way channel select with per-word mask, operating on chunk-skewed data. Chunk k of a word arrives k cycles after chunk 0.
- Sits between `shifter` and `unshifter` in the pipelined-math datapath. It is the generalised successor to `mask`, adding multi-channel selection, a valid qualifier and per-lane control alignment.
- Control (select, mask, valid) is presented with chunk 0 and travels down the lanes so every chunk of a word sees the same control.

Parameters:
- WIDTH, 8: data word width in bits.
- CHUNK, 3: bits per lane. CHUNKS = ceil_division(WIDTH, CHUNK). The last lane is WIDTH-(CHUNKS-1)*CHUNK bits wide.
- NUM_IN, 4: number of input channels, at least 1.
- SEL_W, $clog2(NUM_IN) (minimum 1): select width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset. Asynchronous, active-high.
- en, input, 1: global enable. When low, all registers hold.
- in, input, NUM_IN*WIDTH: skewed channel data. Channel c occupies bits [c*WIDTH +: WIDTH].
- in_sel, input, SEL_W: channel index, aligned with lane 0.
- in_mask, input, 1: 1 passes data, 0 forces zero. Aligned with lane 0.
- in_valid, input, 1: word-valid qualifier, aligned with lane 0.
- out, output, WIDTH: skewed selected/masked data.
- out_valid, output, 1: valid qualifier, aligned with lane 0 of out.

Behaviour:
- Reset: while rst=1, asynchronously clear out=0, out_valid=0 and all control delay registers (sel=0, mask=0, valid=0). Reset mid-word discards the in-flight word. After release, lanes k>0 output 0 until fresh control reaches them.
- Control delay line: depth CHUNKS-1 of {sel, mask, valid}. Stage j holds the control presented j cycles earlier. Lane 0 uses live inputs; lane k uses stage k.
- Lane k output register, updated on each enabled edge:
  - out_lane_k <= mask_k ? in[sel_k channel] lane k : 0.
  - Latency is exactly 1 cycle per lane. The block preserves the input skew.
- out_valid <= in_valid (lane 0 timing). There is no backpressure.
- Out-of-range select (sel_k >= NUM_IN, only possible when NUM_IN is not a power of 2): lane output is 0.
- Consecutive words with different sel/mask on back-to-back cycles must never mix lanes. Each word's chunks all use that word's control.
- en=0: the delay line, lane registers and out_valid all hold. No state advances, so skew alignment is preserved across stalls.
- NUM_IN=1: in_sel is ignored and channel 0 is always selected.
- CHUNKS=1: the delay line is empty and the block is a single registered mux+mask.
- The data path does not qualify data with valid. Invalid words still propagate data, and downstream uses out_valid.

Optional Feature:
- Macro SKEW_MASK_SELECT_RANGE_CHECK_EN.
- Defined:
  - Adds output port out_err (1 bit).
  - out_err <= in_valid & (in_sel >= NUM_IN), aligned with out_valid. Reset value 0; holds under en=0.
  - Data behaviour is unchanged (out-of-range lanes still output 0).
- Undefined: no out_err port and no compare logic. Out-of-range select silently yields 0.

Test Plan (WIDTH=8, CHUNK=3, NUM_IN=4 unless noted; CHUNKS=3, lane widths 3/3/2; data skewed via shifter, out checked per lane):
1. Word 0xA5 on channel 2, sel=2, mask=1, valid=1 at cycle t:
   - lane0 = 5 at t+1, lane1 = 4 at t+2, lane2 = 2 at t+3.
   - out_valid=1 at t+1.
   - After unshifter the word reads 0xA5.
2. Back-to-back words: ch1=0x3C with sel=1 at t, ch3=0xF0 with sel=3 at t+1, other channels carry 0xFF:
   - Unshifted outputs are exactly 0x3C then 0xF0.
   - No 0xFF chunks appear.
3. mask=0 with data 0xFF on all channels, valid=1:
   - All lanes 0.
   - out_valid=1 at t+1.
   - A subsequent mask=1 word passes normally.
4. en low for 2 cycles between lane1 and lane2 of word 0x5A:
   - Outputs hold during the stall.
   - The unshifted result equals 0x5A, delayed 2 cycles versus the unstalled run.
5. rst pulsed asynchronously (between edges) mid-word:
   - out=0 and out_valid=0 immediately.
   - After release, lanes 1/2 output 0 until new control arrives.
   - The first post-reset word 0x81 is correct.
6. NUM_IN=3, sel=3, data 0xFF, valid=1:
   - All lanes 0.
   - With SKEW_MASK_SELECT_RANGE_CHECK_EN defined, out_err=1 at t+1, and 0 for sel=2.

Source files
------------

// File: rtl/skew_mask_select.sv
// skew_mask_select -- pipelined N-way channel select with per-word mask on
// chunk-skewed data. Chunk k of a word arrives k cycles after chunk 0; the
// control (sel, mask) presented with chunk 0 is delayed down a short shift
// register so every chunk of a word is steered by that word's own control.
// Each lane adds exactly one register, so the input skew is preserved.
//
// Optional feature: define SKEW_MASK_SELECT_RANGE_CHECK_EN to add out_err,
// a flag for valid words whose select is out of range.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        global enable; when low every register holds
//   in        NUM_IN skewed channels, channel c at [c*WIDTH +: WIDTH]
//   in_sel    channel index, aligned with lane 0
//   in_mask   1 passes data, 0 forces zero; aligned with lane 0
//   in_valid  word-valid qualifier, aligned with lane 0
//   out       skewed selected/masked data
//   out_valid valid qualifier, aligned with lane 0 of out
//   out_err   (optional) in_valid & out-of-range select, aligned with out_valid

// One lane: registered mux + mask over LW bits of each channel.
module skew_mask_select_lane #(
  parameter int LW     = 3,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_IN-1:0][LW-1:0]  d,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       mask,
  output logic [LW-1:0]              q
);
  logic [LW-1:0] q_nxt;

  // A select that matches no channel (out of range) falls through to zero.
  // With a single channel the select is ignored.
  always_comb begin
    q_nxt = '0;
    for (int c = 0; c < NUM_IN; c++)
      if (mask && (NUM_IN == 1 || sel == SEL_W'(c))) q_nxt = d[c];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= '0;
    else if (en) q <= q_nxt;
endmodule

module skew_mask_select #(
  parameter int WIDTH  = 8,
  parameter int CHUNK  = 3,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_IN*WIDTH-1:0]  in,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_mask,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid
`ifdef SKEW_MASK_SELECT_RANGE_CHECK_EN
  ,
  output logic                     out_err
`endif
);
  localparam int CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int DEPTH  = CHUNKS - 1;
  localparam int QD     = (DEPTH > 0) ? DEPTH : 1;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             mask;
  } ctl_t;

  ctl_t ctl_live;
  ctl_t ctl_q [QD];   // ctl_q[j] = control presented j+1 cycles ago

  assign ctl_live = {in_sel, in_mask};

  // Valid only matters at lane 0 timing, so it is not carried down the
  // delay line; lanes k>0 only need sel/mask.
  if (DEPTH > 0) begin : g_dly
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int j = 0; j < QD; j++) ctl_q[j] <= '0;
      end else if (en) begin
        ctl_q[0] <= ctl_live;
        for (int j = 1; j < QD; j++) ctl_q[j] <= ctl_q[j-1];
      end
  end else begin : g_nodly
    assign ctl_q[0] = '0;
  end

  for (genvar k = 0; k < CHUNKS; k++) begin : g_lane
    localparam int LO = k * CHUNK;
    localparam int LW = (k == CHUNKS - 1) ? WIDTH - LO : CHUNK;

    logic [NUM_IN-1:0][LW-1:0] d;
    ctl_t                      ctl;

    for (genvar c = 0; c < NUM_IN; c++) begin : g_ch
      assign d[c] = in[c*WIDTH + LO +: LW];
    end

    if (k == 0) begin : g_live
      assign ctl = ctl_live;
    end else begin : g_delayed
      assign ctl = ctl_q[k-1];
    end

    skew_mask_select_lane #(.LW(LW), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .d    (d),
      .sel  (ctl.sel),
      .mask (ctl.mask),
      .q    (out[LO +: LW])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)     out_valid <= 1'b0;
    else if (en) out_valid <= in_valid;

`ifdef SKEW_MASK_SELECT_RANGE_CHECK_EN
  logic err_nxt;
  assign err_nxt = in_valid && (NUM_IN > 1) &&
                   ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));

  always_ff @(posedge clk or posedge rst)
    if (rst)     out_err <= 1'b0;
    else if (en) out_err <= err_nxt;
`endif
endmodule
